// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI command decoder: FSM states,
// command byte layout, ID register address and address-advance helper.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  localparam int         CMD_RD_BIT = 7;
  localparam logic [6:0] ID_ADDR    = 7'h7F;
  localparam logic [7:0] DEFAULT_ID = 8'hA5;

  // The ID address is sticky; the register window wraps at its last entry.
  function automatic logic [6:0] next_addr(input logic [6:0] addr, input logic [6:0] last);
    if (addr == ID_ADDR) begin
      return ID_ADDR;
    end else if (addr == last) begin
      return 7'd0;
    end else begin
      return addr + 7'd1;
    end
  endfunction

endpackage

// File: rtl/spi_cs_sync.sv
// Two-flop chip-select synchronizer with rising-edge detect. Latency 2 cycles;
// no flow control. CS is only honoured once it has been seen high after reset.
module spi_cs_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cs_n_i,
  output logic cs_active,
  output logic cs_rise
);

  logic       meta_q, sync_q, prev_q, armed_q, armed_d;
  logic [1:0] fill_q;

  // fill_q marks when sync_q holds a real sample rather than its reset value.
  assign armed_d = armed_q | (sync_q & fill_q[1]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      meta_q  <= cs_n_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_d;
    end
  end

  assign cs_active = armed_q & ~sync_q;
  assign cs_rise   = armed_q & sync_q & ~prev_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Command decoder behind an SPI slave: command byte, then auto-incrementing register
// writes or reads. Writes and TX loads land 1 cycle after i_RX_DV; no backpressure.
module spi_cmd_decoder
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS = 16,
  parameter logic [7:0] ID_VALUE = DEFAULT_ID
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_RX_DV,
  input  logic [7:0]            i_RX_Byte,
  input  logic                  i_SPI_CS_n,
  output logic                  o_TX_DV,
  output logic [7:0]            o_TX_Byte,
  output logic [8*NUM_REGS-1:0] o_Regs,
  output logic                  o_Wr_Strobe,
  output logic [6:0]            o_Wr_Addr
);

  localparam logic [6:0] LAST_ADDR = 7'(NUM_REGS - 1);

  state_e     state_q, state_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] regs_q [NUM_REGS];
  logic       tx_dv_q, tx_dv_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       wr_stb_q, wr_stb_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic       wr_en;
  logic       cs_active, cs_rise;
  logic       rx_take;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;

  spi_cs_sync u_cs_sync (
    .clk_i     (i_Clk),
    .rst_i     (i_Rst),
    .cs_n_i    (i_SPI_CS_n),
    .cs_active (cs_active),
    .cs_rise   (cs_rise)
  );

  // A byte arriving with the CS rise still belongs to the ending transaction.
  assign rx_take = i_RX_DV & (cs_active | cs_rise);
  assign rd_addr = (state_q == ST_IDLE) ? i_RX_Byte[6:0] : addr_q;

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr == ID_ADDR) begin
      rd_data = ID_VALUE;
    end
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr == 7'(k)) begin
        rd_data = regs_q[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_en     = 1'b0;
    if (rx_take) begin
      case (state_q)
        ST_IDLE: begin
          addr_d  = i_RX_Byte[6:0];
          state_d = ST_WRITE;
          if (i_RX_Byte[CMD_RD_BIT]) begin
            state_d   = ST_READ;
            tx_dv_d   = 1'b1;
            tx_byte_d = rd_data;
            addr_d    = next_addr(i_RX_Byte[6:0], LAST_ADDR);
          end
        end
        ST_WRITE: begin
          if (addr_q <= LAST_ADDR) begin
            wr_en     = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = addr_q;
          end
          addr_d = next_addr(addr_q, LAST_ADDR);
        end
        ST_READ: begin
          tx_dv_d   = 1'b1;
          tx_byte_d = rd_data;
          addr_d    = next_addr(addr_q, LAST_ADDR);
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (cs_rise) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= 7'd0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 7'd0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_en && (addr_q == 7'(k))) begin
          regs_q[k] <= i_RX_Byte;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign o_Regs[8*g +: 8] = regs_q[g];
  end

  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Wr_Strobe = wr_stb_q;
  assign o_Wr_Addr   = wr_addr_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: stimulus pushes expected TX loads and register
// writes into queues; a negedge monitor pops and compares each DUT pulse.
module tb_spi_cmd_decoder;
  import spi_reg_pkg::*;

  localparam int K_NONE = 0;
  localparam int K_TX   = 1;
  localparam int K_WR   = 2;

  typedef struct {
    logic [6:0]  a;
    logic [7:0]  d;
    int unsigned cyc;
  } exp_t;

  logic         i_Clk = 1'b0;
  logic         i_Rst;
  logic         i_RX_DV;
  logic [7:0]   i_RX_Byte;
  logic         i_SPI_CS_n;
  logic         o_TX_DV;
  logic [7:0]   o_TX_Byte;
  logic [127:0] o_Regs;
  logic         o_Wr_Strobe;
  logic [6:0]   o_Wr_Addr;

  exp_t        tx_q[$];
  exp_t        wr_q[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  spi_cmd_decoder #(.NUM_REGS(16), .ID_VALUE(8'hA5)) dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_RX_DV     (i_RX_DV),
    .i_RX_Byte   (i_RX_Byte),
    .i_SPI_CS_n  (i_SPI_CS_n),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .o_Regs      (o_Regs),
    .o_Wr_Strobe (o_Wr_Strobe),
    .o_Wr_Addr   (o_Wr_Addr)
  );

  always #5 i_Clk = ~i_Clk;
  always @(posedge i_Clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  always @(negedge i_Clk) begin
    exp_t e;
    if (!i_Rst) begin
      if (o_TX_DV) begin
        if (tx_q.size() == 0) begin
          chk("tx_dv_unexpected", 128'(o_TX_DV), 128'd0);
        end else begin
          e = tx_q.pop_front();
          chk("tx_byte", 128'(o_TX_Byte), 128'(e.d));
          chk("tx_latency", 128'(cyc), 128'(e.cyc));
        end
      end
      if (o_Wr_Strobe) begin
        if (wr_q.size() == 0) begin
          chk("wr_strobe_unexpected", 128'(o_Wr_Strobe), 128'd0);
        end else begin
          e = wr_q.pop_front();
          chk("wr_addr", 128'(o_Wr_Addr), 128'(e.a));
          chk("wr_data", 128'(o_Regs[int'(e.a)*8 +: 8]), 128'(e.d));
          chk("wr_latency", 128'(cyc), 128'(e.cyc));
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input int kind, input logic [6:0] a, input logic [7:0] d);
    exp_t e;
    @(posedge i_Clk);
    #1;
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    e.a   = a;
    e.d   = d;
    e.cyc = cyc + 1;
    if (kind == K_TX) tx_q.push_back(e);
    if (kind == K_WR) wr_q.push_back(e);
    @(posedge i_Clk);
    #1;
    i_RX_DV = 1'b0;
    repeat (3) @(posedge i_Clk);
  endtask

  task automatic cs_low();
    @(posedge i_Clk);
    #1 i_SPI_CS_n = 1'b0;
    repeat (3) @(posedge i_Clk);
  endtask

  task automatic cs_high();
    @(posedge i_Clk);
    #1 i_SPI_CS_n = 1'b1;
    repeat (4) @(posedge i_Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] IMG_A = 128'h2211_0000_0000_0000_0000_006B_5A00_8877;

  initial begin
    i_Rst = 1'b1; i_RX_DV = 1'b0; i_RX_Byte = 8'h00; i_SPI_CS_n = 1'b1;
    repeat (3) @(posedge i_Clk);
    #1;
    chk("rst_tx_dv", 128'(o_TX_DV), 128'd0);
    chk("rst_tx_byte", 128'(o_TX_Byte), 128'd0);
    chk("rst_wr_strobe", 128'(o_Wr_Strobe), 128'd0);
    chk("rst_wr_addr", 128'(o_Wr_Addr), 128'd0);
    chk("rst_regs", o_Regs, 128'd0);
    chk("rst_state", 128'(dut.state_q), 128'(ST_IDLE));
    i_Rst = 1'b0;
    repeat (4) @(posedge i_Clk);

    // Write burst at address 3
    cs_low();
    send(8'h03, K_NONE, 7'h0, 8'h00);
    send(8'h5A, K_WR, 7'h03, 8'h5A);
    send(8'h6B, K_WR, 7'h04, 8'h6B);
    cs_high();
    #1;
    chk("burst_wr_addr_final", 128'(o_Wr_Addr), 128'h04);
    chk("burst_reg3", 128'(o_Regs[31:24]), 128'h5A);
    chk("burst_reg4", 128'(o_Regs[39:32]), 128'h6B);

    // Write burst wrapping 15 -> 0
    cs_low();
    send(8'h0E, K_NONE, 7'h0, 8'h00);
    send(8'h11, K_WR, 7'h0E, 8'h11);
    send(8'h22, K_WR, 7'h0F, 8'h22);
    send(8'h77, K_WR, 7'h00, 8'h77);
    send(8'h88, K_WR, 7'h01, 8'h88);
    cs_high();

    // Read burst wrapping 15 -> 0
    cs_low();
    send(8'h8E, K_TX, 7'h0, 8'h11);
    send(8'h00, K_TX, 7'h0, 8'h22);
    send(8'h00, K_TX, 7'h0, 8'h77);
    send(8'h00, K_TX, 7'h0, 8'h88);
    cs_high();

    // ID register read is sticky; writes there are dropped
    cs_low();
    send(8'hFF, K_TX, 7'h0, 8'hA5);
    send(8'h00, K_TX, 7'h0, 8'hA5);
    send(8'h00, K_TX, 7'h0, 8'hA5);
    cs_high();
    cs_low();
    send(8'h7F, K_NONE, 7'h0, 8'h00);
    send(8'h00, K_NONE, 7'h0, 8'h00);
    cs_high();
    #1 chk("id_write_regs_unchanged", o_Regs, IMG_A);

    // Out-of-range address
    cs_low();
    send(8'h20, K_NONE, 7'h0, 8'h00);
    send(8'h99, K_NONE, 7'h0, 8'h00);
    cs_high();
    #1 chk("oor_write_regs_unchanged", o_Regs, IMG_A);
    cs_low();
    send(8'hA0, K_TX, 7'h0, 8'h00);
    send(8'h00, K_TX, 7'h0, 8'h00);
    cs_high();

    // Last data byte coincides with the synchronized CS rise
    cs_low();
    send(8'h05, K_NONE, 7'h0, 8'h00);
    @(posedge i_Clk);
    #1 i_SPI_CS_n = 1'b1;
    @(posedge i_Clk);
    send(8'hC3, K_WR, 7'h05, 8'hC3);
    chk("cs_rise_state_idle", 128'(dut.state_q), 128'(ST_IDLE));
    cs_low();
    send(8'h85, K_TX, 7'h0, 8'hC3);
    cs_high();

    // Reset between write command and its data, CS held low
    cs_low();
    send(8'h02, K_NONE, 7'h0, 8'h00);
    @(posedge i_Clk);
    #1 i_Rst = 1'b1;
    repeat (2) @(posedge i_Clk);
    #1;
    chk("midrst_regs", o_Regs, 128'd0);
    chk("midrst_state", 128'(dut.state_q), 128'(ST_IDLE));
    chk("midrst_wr_addr", 128'(o_Wr_Addr), 128'd0);
    chk("midrst_tx_byte", 128'(o_TX_Byte), 128'd0);
    i_Rst = 1'b0;
    repeat (4) @(posedge i_Clk);
    send(8'h44, K_NONE, 7'h0, 8'h00);
    #1 chk("postrst_byte_ignored", o_Regs, 128'd0);
    cs_high();
    cs_low();
    send(8'h02, K_NONE, 7'h0, 8'h00);
    send(8'h55, K_WR, 7'h02, 8'h55);
    cs_high();
    #1 chk("postrst_new_cmd", o_Regs, 128'h0055_0000);

    repeat (5) @(posedge i_Clk);
    chk("tx_queue_drained", 128'(tx_q.size()), 128'd0);
    chk("wr_queue_drained", 128'(wr_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
